// File: rtl/priority_index_decoder16_if.sv
// Handshake bundle for the priority index decoder: index beats in, rebuilt frames out.
interface priority_index_decoder16_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDXW  = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [IDXW-1:0] in_idx;
  logic            in_null;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [WIDTH-1:0] out_vec;
  logic [IDXW:0]   out_count;
  logic            out_dup;

  modport master (
    output in_valid, in_idx, in_null, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_dup
  );

  modport slave (
    input  in_valid, in_idx, in_null, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_dup
  );
endinterface

// File: rtl/priority_index_decoder16.sv
// Rebuilds an MSB-first priority vector from a framed stream of indices and
// presents each completed frame with its popcount and a duplicate flag.
module priority_index_decoder16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDXW  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  priority_index_decoder16_if.slave   bus
);

  if (IDXW != $clog2(WIDTH) || (WIDTH & (WIDTH - 1)) != 0) begin : g_param_check
    $error("priority_index_decoder16: WIDTH must be a power of two and IDXW == log2(WIDTH)");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             dup_acc;
  logic             out_valid;
  logic [WIDTH-1:0] out_vec;
  logic [IDXW:0]    out_count;
  logic             out_dup;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] next_vec;
  logic             next_dup;
  logic [IDXW:0]    next_count;

  always_comb begin
    in_ready = !out_valid || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    base     = (state == IDLE) ? '0 : acc;
    // WIDTH is 2**IDXW, so ~idx equals WIDTH-1-idx
    onehot   = bus.in_null ? '0 : (WIDTH'(1) << (~bus.in_idx));
    next_vec = base | onehot;
    next_dup = ((state == IDLE) ? 1'b0 : dup_acc) || ((base & onehot) != '0);
    next_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      next_count = next_count + (IDXW+1)'(next_vec[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      dup_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
    end else begin
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (bus.in_last) begin
          out_vec   <= next_vec;
          out_count <= next_count;
          out_dup   <= next_dup;
          out_valid <= 1'b1;
          acc       <= '0;
          dup_acc   <= 1'b0;
          state     <= IDLE;
        end else begin
          acc       <= next_vec;
          dup_acc   <= next_dup;
          state     <= ACCUM;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_vec   = out_vec;
  assign bus.out_count = out_count;
  assign bus.out_dup   = out_dup;

endmodule

// File: doc/priority_index_decoder16.md
Name: priority_index_decoder16

Overview:
- Inverse of the team's 16-bit MSB-first priority encoder.
- Accepts a stream of 4-bit priority indices and rebuilds the 16-bit vector they describe.
- Index 0 means bit 15 (MSB) and index 15 means bit 0, matching the encoder convention.
- Frames are delimited by a last flag. Each completed frame is presented on a registered output with valid/ready handshake, a popcount and a duplicate flag.

Parameters:
- WIDTH, 16, reconstructed vector width; power of two only.
- IDXW, 4, index width; must equal log2(WIDTH); elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  index beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_idx  input  IDXW  priority index (0 = bit WIDTH-1)
- in_null  input  1  beat carries no index (the encoder's "no bit set" case); in_idx is ignored
- in_last  input  1  final beat of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts the result
- out_vec  output  WIDTH  reconstructed vector
- out_count  output  IDXW+1  number of distinct bits set in out_vec (0..WIDTH)
- out_dup  output  1  an index was received more than once in the frame

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_vec=0, out_count=0, out_dup=0.
  - Internal accumulator and dup tracker cleared; state=IDLE.
  - in_ready reflects reset state, i.e. 1.
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. Combinational from out_ready; no input register.
- Decode of an accepted non-null beat:
  - onehot = 1 << (WIDTH-1-in_idx).
  - If (acc & onehot) != 0, dup_acc sets.
  - acc |= onehot.
- Null beat: acc unchanged and dup unchanged, but it still advances the frame and honours in_last.
- States:
  - IDLE: acc==0, no beats yet in frame.
  - ACCUM: at least one beat accepted, last not yet seen.
  - In either state, an accepted beat with in_last=1 completes the frame.
- Frame completion:
  - On the clock edge accepting the last beat, load out_vec = acc | onehot (acc alone if null) and out_dup = dup_acc including this beat.
  - out_count = popcount of the loaded out_vec.
  - out_valid=1. Latency is one cycle from the last-beat edge to out_valid.
  - acc and dup_acc clear in the same edge; state returns to IDLE.
- Output hold: out_vec, out_count and out_dup are stable while out_valid && !out_ready.
- Output release: out_valid drops on the edge where out_ready=1, unless a new frame completes on that same edge. In that case the output reloads with the new frame and out_valid stays 1, giving back-to-back frames at one per cycle.
- Back-pressure: non-last beats are also stalled while the output is held full (simple uniform rule).
- Single-beat frame (in_last on first beat): valid; produces a one-hot result, or all-zero with count 0 if null.
- Full frame: all 16 distinct indices give out_vec=16'hFFFF and out_count=16. Count width IDXW+1 holds WIDTH exactly; no wrap.
- No frame-length limit: beats beyond WIDTH are necessarily duplicates, flagged by out_dup; acc cannot overflow.
- in_idx, in_null and in_last are don't-care when in_valid=0. Beats are not accepted while in_ready=0, and upstream must hold them stable.
- Reset mid-frame or while output is held discards everything. No result is emitted for a partial frame.

Test Plan:
- Reset then frame {idx 0 last} → next cycle out_valid=1, out_vec=16'h8000, out_count=1, out_dup=0.
- Frame {3, 15, 7 last}, out_ready=1 → out_vec=16'h1101, out_count=3, out_dup=0; out_valid for exactly one cycle.
- Frame {5, 5 last} → out_vec=16'h0400, out_count=1, out_dup=1; next frame {null last} → out_vec=0, out_count=0, out_dup=0.
- Indices 0..15 with last on 15 → out_vec=16'hFFFF, out_count=16. Also loop-back: feed encoder output for in=16'h0020 → out_vec=16'h0020.
- out_ready=0 with frame {2 last} held:
  - in_ready=0 and out_vec=16'h2000 stays stable for 5 cycles.
  - Then raise out_ready with frame {9 last} waiting: same edge reloads out_vec=16'h0040 and out_valid stays 1.
- Assert rst after beats {1, 4} with no last → all outputs 0 immediately. Then frame {6 last} gives out_vec=16'h0200, with no bits from the aborted frame.
